// File: rtl/aes128_round_ctrl_pkg.sv
// Shared definitions for the iterative AES-128 encryptor.
//   - FSM state encodings (3-bit) and the fixed AES-128 round count
//   - GF(2^8) helpers (xtime / mult2 / mult3 / gf_mul / inverse)
//   - S-box, computed as the GF(2^8) inverse followed by the affine map
//   - whole-state SubBytes, ShiftRows and MixColumns transforms
// Byte order everywhere: byte 0 at [127:120], column c at [127-32c -: 32],
// row r of column c is byte 4c+r.
package aes128_round_ctrl_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_INIT  = 3'd1;
  localparam logic [2:0] ST_ROUND = 3'd2;
  localparam logic [2:0] ST_FINAL = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam int AES_NUM_ROUNDS = 10;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mult2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] mult3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  // Shift-and-add multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] a_sh;
    acc  = 8'h00;
    a_sh = a;
    for (int i = 0; i < 8; i++) begin
      acc  = acc ^ (b[i] ? a_sh : 8'h00);
      a_sh = xtime(a_sh);
    end
    return acc;
  endfunction

  // Multiplicative inverse as x^254 (x^2 * x^4 * ... * x^128); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  // AES S-box: inverse, then b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = gf_inv(x);
    return inv
         ^ {inv[6:0], inv[7]}
         ^ {inv[5:0], inv[7:6]}
         ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]}
         ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = 128'd0;
    for (int i = 0; i < 16; i++) begin
      r[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    end
    return r;
  endfunction

  // Row r rotates left by r columns: out[r][c] = in[r][(c+r) mod 4].
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r_out;
    r_out = 128'd0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        r_out[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return r_out;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r_out;
    logic [7:0]   a0;
    logic [7:0]   a1;
    logic [7:0]   a2;
    logic [7:0]   a3;
    r_out = 128'd0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r_out[127-32*c -: 8] = mult2(a0) ^ mult3(a1) ^ a2 ^ a3;
      r_out[119-32*c -: 8] = a0 ^ mult2(a1) ^ mult3(a2) ^ a3;
      r_out[111-32*c -: 8] = a0 ^ a1 ^ mult2(a2) ^ mult3(a3);
      r_out[103-32*c -: 8] = mult3(a0) ^ a1 ^ a2 ^ mult2(a3);
    end
    return r_out;
  endfunction

endpackage

// File: rtl/aes128_round_ctrl_key_step.sv
// aes128_key_step: one AES-128 key-expansion step, purely combinational.
// Ports:
//   key      in  128  current round key (w0..w3, w0 at [127:96])
//   rcon     in  8    round constant for the key being produced
//   next_key out 128  following round key
// Its four S-boxes are independent of the sixteen used by the state path.
module aes128_key_step
  import aes128_round_ctrl_pkg::*;
(
  input  logic [127:0] key,
  input  logic [7:0]   rcon,
  output logic [127:0] next_key
);

  logic [31:0] w0_s;
  logic [31:0] w1_s;
  logic [31:0] w2_s;
  logic [31:0] w3_s;
  logic [31:0] rot_s;
  logic [31:0] sub_s;
  logic [31:0] n0_s;
  logic [31:0] n1_s;
  logic [31:0] n2_s;
  logic [31:0] n3_s;

  assign w0_s = key[127:96];
  assign w1_s = key[95:64];
  assign w2_s = key[63:32];
  assign w3_s = key[31:0];

  // RotWord moves the top byte to the bottom.
  assign rot_s = {w3_s[23:0], w3_s[31:24]};

  assign sub_s = {sbox(rot_s[31:24]), sbox(rot_s[23:16]),
                  sbox(rot_s[15:8]),  sbox(rot_s[7:0])};

  assign n0_s = w0_s ^ sub_s ^ {rcon, 24'h000000};
  assign n1_s = w1_s ^ n0_s;
  assign n2_s = w2_s ^ n1_s;
  assign n3_s = w3_s ^ n2_s;

  assign next_key = {n0_s, n1_s, n2_s, n3_s};

endmodule

// File: rtl/aes128_round_ctrl.sv
// aes128_round_ctrl: iterative AES-128 encryptor, one cipher round per clock.
// A block is latched on the input handshake, whitened with the cipher key
// (INIT), run through nine full rounds (ROUND) and one round without
// MixColumns (FINAL), then presented until the consumer takes it (DONE).
// Round keys are expanded on the fly alongside the state.
// Ports:
//   clk       in  1    rising-edge clock
//   rst_n     in  1    asynchronous active-low reset
//   in_valid  in  1    in_data / in_key valid
//   in_ready  out 1    high in IDLE, or in DONE while out_ready is high
//   in_data   in  128  plaintext
//   in_key    in  128  cipher key
//   out_valid out 1    out_data holds a finished ciphertext
//   out_ready in  1    consumer accepts when out_valid & out_ready
//   out_data  out 128  ciphertext
//   busy      out 1    high in INIT, ROUND, FINAL
//   round     out 4    round being computed (0 = initial AddRoundKey)
module aes128_round_ctrl
  import aes128_round_ctrl_pkg::*;
#(
  parameter int         NUM_ROUNDS = 10,
  parameter logic [7:0] RCON_INIT  = 8'h01
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output logic [3:0]   round
);

  if (NUM_ROUNDS != AES_NUM_ROUNDS) begin : g_bad_rounds
    $error("aes128_round_ctrl: NUM_ROUNDS must be 10 for AES-128");
  end

  // Last round index handled in ROUND; the one after it is FINAL.
  localparam logic [3:0] LAST_MID_ROUND = 4'(NUM_ROUNDS - 1);

  logic [2:0]   fsm_r;
  logic [127:0] state_r;
  logic [127:0] key_r;
  logic [7:0]   rcon_r;
  logic [3:0]   round_r;

  logic [127:0] next_key_s;
  logic [127:0] sb_s;
  logic [127:0] sr_s;
  logic [127:0] mc_s;
  logic [127:0] round_out_s;
  logic         in_ready_s;
  logic         accept_s;

  aes128_key_step u_key_step (
    .key      (key_r),
    .rcon     (rcon_r),
    .next_key (next_key_s)
  );

  // Shared round datapath; FINAL takes the ShiftRows result past MixColumns.
  always_comb begin
    sb_s = sub_bytes(state_r);
    sr_s = shift_rows(sb_s);
    mc_s = mix_columns(sr_s);
    if (fsm_r == ST_FINAL) begin
      round_out_s = sr_s ^ next_key_s;
    end else begin
      round_out_s = mc_s ^ next_key_s;
    end
  end

  // Input acceptance: idle, or handing off the finished block this cycle.
  always_comb begin
    case (fsm_r)
      ST_IDLE: in_ready_s = 1'b1;
      ST_DONE: in_ready_s = out_ready;
      default: in_ready_s = 1'b0;
    endcase
  end

  assign accept_s = in_valid & in_ready_s;

  // Round sequencer: FSM, cipher state, round key, rcon and round index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_r   <= ST_IDLE;
      state_r <= 128'd0;
      key_r   <= 128'd0;
      rcon_r  <= RCON_INIT;
      round_r <= 4'd0;
    end else begin
      case (fsm_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r <= in_data;
            key_r   <= in_key;
            rcon_r  <= RCON_INIT;
            round_r <= 4'd0;
            fsm_r   <= ST_INIT;
          end
        end
        ST_INIT: begin
          state_r <= state_r ^ key_r;
          round_r <= 4'd1;
          fsm_r   <= ST_ROUND;
        end
        ST_ROUND: begin
          state_r <= round_out_s;
          key_r   <= next_key_s;
          rcon_r  <= xtime(rcon_r);
          round_r <= round_r + 4'd1;
          if (round_r == LAST_MID_ROUND) begin
            fsm_r <= ST_FINAL;
          end
        end
        ST_FINAL: begin
          state_r <= round_out_s;
          key_r   <= next_key_s;
          rcon_r  <= xtime(rcon_r);
          fsm_r   <= ST_DONE;
        end
        ST_DONE: begin
          // Output hand-off and next accept can share a cycle.
          if (accept_s) begin
            state_r <= in_data;
            key_r   <= in_key;
            rcon_r  <= RCON_INIT;
            round_r <= 4'd0;
            fsm_r   <= ST_INIT;
          end else if (out_ready) begin
            round_r <= 4'd0;
            fsm_r   <= ST_IDLE;
          end
        end
        default: begin
          fsm_r   <= ST_IDLE;
          round_r <= 4'd0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = (fsm_r == ST_DONE);
  assign out_data  = state_r;
  assign busy      = (fsm_r == ST_INIT) | (fsm_r == ST_ROUND) | (fsm_r == ST_FINAL);
  assign round     = round_r;

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// Directed bench for aes128_round_ctrl using published AES-128 vectors.
module tb_aes128_round_ctrl;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
  logic [3:0]   round;

  int n_checks;
  int n_fail;

  localparam logic [127:0] B_DATA = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_EXP  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C_DATA = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_EXP  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] Z_EXP  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] S_DATA = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] S_EXP  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

  aes128_round_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .round     (round)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic got, input logic exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chkn(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts one cycle after the accept edge (INIT); ends in DONE, 12 cycles after accept.
  task automatic finish_block(input logic [127:0] exp, input bit chk_rounds, input bit poke);
    int er;
    for (int i = 1; i <= 11; i++) begin
      chkb("busy_run", busy, 1'b1);
      chkb("no_early_valid", out_valid, 1'b0);
      if (chk_rounds) begin
        er = (i == 1) ? 0 : ((i == 11) ? 10 : i - 1);
        chkn("round_step", round, 4'(er));
      end
      if (poke && i == 5) begin
        in_valid = 1'b1;
        in_data  = ~B_DATA;
        in_key   = ~B_KEY;
        #1;
        chkb("poke_in_ready", in_ready, 1'b0);
      end
      if (poke && i == 6) begin
        in_valid = 1'b0;
      end
      tick();
    end
    chkb("out_valid_at_12", out_valid, 1'b1);
    chk("ciphertext", out_data, exp);
    chkb("busy_done", busy, 1'b0);
    chkn("round_done", round, 4'd10);
  endtask

  task automatic run_block(input logic [127:0] d, input logic [127:0] k,
                           input logic [127:0] exp, input bit chk_rounds, input bit poke);
    chkb("idle_in_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = d;
    in_key   = k;
    tick();
    in_valid = 1'b0;
    finish_block(exp, chk_rounds, poke);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chkb("drain_out_valid", out_valid, 1'b0);
  endtask

  logic [127:0] bb_d [4];
  logic [127:0] bb_k [4];
  logic [127:0] bb_e [4];

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 128'd0;
    in_key    = 128'd0;
    out_ready = 1'b0;

    // Reset values
    #3 rst_n = 1'b0;
    tick();
    tick();
    chkb("rst_in_ready", in_ready, 1'b1);
    chkb("rst_out_valid", out_valid, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    chkn("rst_round", round, 4'd0);
    chk("rst_out_data", out_data, 128'd0);
    rst_n = 1'b1;
    tick();

    // App. B, exact latency
    run_block(B_DATA, B_KEY, B_EXP, 1'b0, 1'b0);
    drain();

    // App. C.1 with round sequence, then backpressure with a queued block
    run_block(C_DATA, C_KEY, C_EXP, 1'b1, 1'b0);
    in_valid = 1'b1;
    in_data  = B_DATA;
    in_key   = B_KEY;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_stable", out_data, C_EXP);
      chkb("bp_in_ready", in_ready, 1'b0);
      chkb("bp_out_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    #1;
    chkb("release_in_ready", in_ready, 1'b1);
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    finish_block(B_EXP, 1'b0, 1'b0);
    drain();

    // Mid-flight input poke
    run_block(B_DATA, B_KEY, B_EXP, 1'b0, 1'b1);
    drain();

    // Back-to-back, in_valid and out_ready held high
    bb_d[0] = B_DATA;  bb_k[0] = B_KEY;  bb_e[0] = B_EXP;
    bb_d[1] = C_DATA;  bb_k[1] = C_KEY;  bb_e[1] = C_EXP;
    bb_d[2] = 128'd0;  bb_k[2] = 128'd0; bb_e[2] = Z_EXP;
    bb_d[3] = S_DATA;  bb_k[3] = B_KEY;  bb_e[3] = S_EXP;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = bb_d[0];
    in_key    = bb_k[0];
    #1;
    chkb("b2b_first_ready", in_ready, 1'b1);
    for (int b = 0; b < 4; b++) begin
      tick();
      if (b < 3) begin
        in_data = bb_d[b+1];
        in_key  = bb_k[b+1];
      end else begin
        in_valid = 1'b0;
      end
      for (int j = 0; j < 10; j++) begin
        tick();
      end
      chkb("b2b_not_yet", out_valid, 1'b0);
      tick();
      chkb("b2b_valid", out_valid, 1'b1);
      chk("b2b_data", out_data, bb_e[b]);
      chkb("b2b_in_ready", in_ready, 1'b1);
    end
    tick();
    out_ready = 1'b0;
    chkb("b2b_idle", busy, 1'b0);

    // Asynchronous reset at round 5, then a fresh App. C.1 block
    chkb("pre_rst_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = B_DATA;
    in_key   = B_KEY;
    tick();
    in_valid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      tick();
    end
    chkn("at_round5", round, 4'd5);
    rst_n = 1'b0;
    #1;
    chkb("arst_out_valid", out_valid, 1'b0);
    chkb("arst_busy", busy, 1'b0);
    chkn("arst_round", round, 4'd0);
    chkb("arst_in_ready", in_ready, 1'b1);
    chk("arst_out_data", out_data, 128'd0);
    #2 rst_n = 1'b1;
    for (int j = 0; j < 14; j++) begin
      tick();
      chkb("post_rst_no_valid", out_valid, 1'b0);
    end
    run_block(C_DATA, C_KEY, C_EXP, 1'b1, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
